// File: rtl/mem_bus_arb_pkg.sv
// Shared definitions for the memory bus arbiter: FSM state encoding,
// default bus geometry and a small index-width helper.
package mem_bus_arb_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_BUSY = 2'd1,
      ARB_RESP = 2'd2
   } arb_state_e;

   localparam int DEF_NUM_CH  = 2;
   localparam int DEF_AW      = 32;
   localparam int DEF_DW      = 32;
   localparam int DEF_TIMEOUT = 255;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mem_bus_arb_rr_pick.sv
// Combinational round-robin picker: lowest requester strictly above last_i,
// otherwise wrap around to the lowest requester overall.
module mem_bus_arb_rr_pick
   import mem_bus_arb_pkg::*;
#(
   parameter int NUM_CH = DEF_NUM_CH,
   parameter int IW     = idx_w(NUM_CH)
) (
   input  logic [NUM_CH-1:0] req_i,
   input  logic [IW-1:0]     last_i,
   output logic [IW-1:0]     grant_o,
   output logic              valid_o
);

   logic [NUM_CH-1:0] upper_mask;
   logic [NUM_CH-1:0] upper_req;
   logic [IW-1:0]     upper_idx;
   logic [IW-1:0]     any_idx;
   logic              upper_hit;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_mask
         assign upper_mask[gi] = (IW'(gi) > last_i);
      end
   endgenerate

   assign upper_req = req_i & upper_mask;

   // Descending scan so the lowest set index is the one left standing.
   always_comb begin
      upper_hit = 1'b0;
      upper_idx = '0;
      any_idx   = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (upper_req[i]) begin
            upper_hit = 1'b1;
            upper_idx = IW'(i);
         end
         if (req_i[i]) begin
            any_idx = IW'(i);
         end
      end
   end

   assign grant_o = upper_hit ? upper_idx : any_idx;
   assign valid_o = |req_i;

endmodule

// File: rtl/mem_bus_arb.sv
// N-channel round-robin arbiter onto a single memory bus; tolerates variable
// slave latency and aborts a hung slave after TIMEOUT busy cycles.
module mem_bus_arb
   import mem_bus_arb_pkg::*;
#(
   parameter int NUM_CH  = DEF_NUM_CH,
   parameter int AW      = DEF_AW,
   parameter int DW      = DEF_DW,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_CH-1:0]      ch_req_i,
   input  logic [NUM_CH-1:0]      ch_we_i,
   input  logic [NUM_CH*AW-1:0]   ch_addr_i,
   input  logic [NUM_CH*DW-1:0]   ch_wdata_i,
   input  logic [NUM_CH*DW/8-1:0] ch_sel_i,
   output logic [NUM_CH-1:0]      ch_ack_o,
   output logic [NUM_CH-1:0]      ch_err_o,
   output logic [DW-1:0]          ch_rdata_o,
   output logic [NUM_CH-1:0]      stall_o,
   output logic                   bus_req_o,
   output logic                   bus_we_o,
   output logic [AW-1:0]          bus_addr_o,
   output logic [DW-1:0]          bus_wdata_o,
   output logic [DW/8-1:0]        bus_sel_o,
   input  logic                   bus_ack_i,
   input  logic [DW-1:0]          bus_rdata_i
);

   localparam int IW = idx_w(NUM_CH);
   localparam int SW = DW / 8;
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TO_CNT   = CW'(TIMEOUT);
   localparam logic [IW-1:0] LAST_RST = IW'(NUM_CH - 1);

   logic [AW-1:0] ch_addr_a  [NUM_CH];
   logic [DW-1:0] ch_wdata_a [NUM_CH];
   logic [SW-1:0] ch_sel_a   [NUM_CH];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_unpack
         assign ch_addr_a[gi]  = ch_addr_i[gi*AW +: AW];
         assign ch_wdata_a[gi] = ch_wdata_i[gi*DW +: DW];
         assign ch_sel_a[gi]   = ch_sel_i[gi*SW +: SW];
      end
   endgenerate

   arb_state_e    state_q,     state_d;
   logic [IW-1:0] grant_q,     grant_d;
   logic [IW-1:0] last_q,      last_d;
   logic [CW-1:0] cnt_q,       cnt_d;
   logic          bus_req_q,   bus_req_d;
   logic          bus_we_q,    bus_we_d;
   logic [AW-1:0] bus_addr_q,  bus_addr_d;
   logic [DW-1:0] bus_wdata_q, bus_wdata_d;
   logic [SW-1:0] bus_sel_q,   bus_sel_d;
   logic [NUM_CH-1:0] ch_ack_q, ch_ack_d;
   logic [NUM_CH-1:0] ch_err_q, ch_err_d;
   logic [DW-1:0] rdata_q,     rdata_d;

   logic [IW-1:0] pick_idx;
   logic          pick_valid;

   mem_bus_arb_rr_pick #(
      .NUM_CH (NUM_CH),
      .IW     (IW)
   ) u_rr_pick (
      .req_i   (ch_req_i),
      .last_i  (last_q),
      .grant_o (pick_idx),
      .valid_o (pick_valid)
   );

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      last_d      = last_q;
      cnt_d       = cnt_q;
      bus_req_d   = bus_req_q;
      bus_we_d    = bus_we_q;
      bus_addr_d  = bus_addr_q;
      bus_wdata_d = bus_wdata_q;
      bus_sel_d   = bus_sel_q;
      ch_ack_d    = '0;
      ch_err_d    = '0;
      rdata_d     = '0;

      unique case (state_q)
         ARB_IDLE: begin
            if (pick_valid) begin
               grant_d     = pick_idx;
               last_d      = pick_idx;
               bus_req_d   = 1'b1;
               bus_we_d    = ch_we_i[pick_idx];
               bus_addr_d  = ch_addr_a[pick_idx];
               bus_wdata_d = ch_wdata_a[pick_idx];
               bus_sel_d   = ch_sel_a[pick_idx];
               state_d     = ARB_BUSY;
            end
         end
         ARB_BUSY: begin
            // Ack is tested first so an ack on the timeout cycle is not an error.
            if (bus_ack_i) begin
               bus_req_d         = 1'b0;
               ch_ack_d[grant_q] = 1'b1;
               if (!bus_we_q) begin
                  rdata_d = bus_rdata_i;
               end
               state_d = ARB_RESP;
            end else if (cnt_q == TO_CNT) begin
               bus_req_d         = 1'b0;
               ch_ack_d[grant_q] = 1'b1;
               ch_err_d[grant_q] = 1'b1;
               state_d           = ARB_RESP;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ARB_RESP: begin
            cnt_d   = '0;
            state_d = ARB_IDLE;
         end
         default: begin
            state_d = ARB_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ARB_IDLE;
         grant_q     <= '0;
         last_q      <= LAST_RST;
         cnt_q       <= '0;
         bus_req_q   <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_addr_q  <= '0;
         bus_wdata_q <= '0;
         bus_sel_q   <= '0;
         ch_ack_q    <= '0;
         ch_err_q    <= '0;
         rdata_q     <= '0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         last_q      <= last_d;
         cnt_q       <= cnt_d;
         bus_req_q   <= bus_req_d;
         bus_we_q    <= bus_we_d;
         bus_addr_q  <= bus_addr_d;
         bus_wdata_q <= bus_wdata_d;
         bus_sel_q   <= bus_sel_d;
         ch_ack_q    <= ch_ack_d;
         ch_err_q    <= ch_err_d;
         rdata_q     <= rdata_d;
      end
   end

   assign ch_ack_o    = ch_ack_q;
   assign ch_err_o    = ch_err_q;
   assign ch_rdata_o  = rdata_q;
   assign stall_o     = ch_req_i & ~ch_ack_q;
   assign bus_req_o   = bus_req_q;
   assign bus_we_o    = bus_we_q;
   assign bus_addr_o  = bus_addr_q;
   assign bus_wdata_o = bus_wdata_q;
   assign bus_sel_o   = bus_sel_q;

endmodule

// File: tb/tb_mem_bus_arb.sv
// Bench for mem_bus_arb: directed vector table, hand-written corner sequences
// and a randomized run against a transaction-level arbitration model.
module tb_mem_bus_arb;

   localparam int NUM_CH  = 4;
   localparam int AW      = 32;
   localparam int DW      = 32;
   localparam int SW      = DW / 8;
   localparam int TIMEOUT = 8;
   localparam int NEVER   = 99;

   logic                   clk = 1'b0;
   logic                   rst;
   logic [NUM_CH-1:0]      ch_req_i;
   logic [NUM_CH-1:0]      ch_we_i;
   logic [NUM_CH*AW-1:0]   ch_addr_i;
   logic [NUM_CH*DW-1:0]   ch_wdata_i;
   logic [NUM_CH*SW-1:0]   ch_sel_i;
   logic [NUM_CH-1:0]      ch_ack_o;
   logic [NUM_CH-1:0]      ch_err_o;
   logic [DW-1:0]          ch_rdata_o;
   logic [NUM_CH-1:0]      stall_o;
   logic                   bus_req_o;
   logic                   bus_we_o;
   logic [AW-1:0]          bus_addr_o;
   logic [DW-1:0]          bus_wdata_o;
   logic [SW-1:0]          bus_sel_o;
   logic                   bus_ack_i;
   logic [DW-1:0]          bus_rdata_i;

   mem_bus_arb #(
      .NUM_CH  (NUM_CH),
      .AW      (AW),
      .DW      (DW),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .ch_req_i    (ch_req_i),
      .ch_we_i     (ch_we_i),
      .ch_addr_i   (ch_addr_i),
      .ch_wdata_i  (ch_wdata_i),
      .ch_sel_i    (ch_sel_i),
      .ch_ack_o    (ch_ack_o),
      .ch_err_o    (ch_err_o),
      .ch_rdata_o  (ch_rdata_o),
      .stall_o     (stall_o),
      .bus_req_o   (bus_req_o),
      .bus_we_o    (bus_we_o),
      .bus_addr_o  (bus_addr_o),
      .bus_wdata_o (bus_wdata_o),
      .bus_sel_o   (bus_sel_o),
      .bus_ack_i   (bus_ack_i),
      .bus_rdata_i (bus_rdata_i)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Master-side view of each channel: what the bench is currently driving.
   logic [NUM_CH-1:0] m_req;
   logic [NUM_CH-1:0] m_we;
   logic [AW-1:0]     m_addr  [NUM_CH];
   logic [DW-1:0]     m_wdata [NUM_CH];
   logic [SW-1:0]     m_sel   [NUM_CH];

   typedef struct {
      int          ch;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  sel;
      int          wait_n;
      logic [31:0] srd;
      int          ack_cyc;
      logic        err;
      logic [31:0] exp_rd;
   } vec_t;

   vec_t vecs [7];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic apply();
      for (int i = 0; i < NUM_CH; i++) begin
         ch_req_i[i]             = m_req[i];
         ch_we_i[i]              = m_we[i];
         ch_addr_i[i*AW +: AW]   = m_addr[i];
         ch_wdata_i[i*DW +: DW]  = m_wdata[i];
         ch_sel_i[i*SW +: SW]    = m_sel[i];
      end
   endtask

   task automatic clear_masters();
      m_req = '0;
      m_we  = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         m_addr[i]  = '0;
         m_wdata[i] = '0;
         m_sel[i]   = '0;
      end
      apply();
   endtask

   task automatic new_req(input int c);
      m_req[c]   = 1'b1;
      m_we[c]    = 1'($urandom_range(0, 1));
      m_addr[c]  = $urandom;
      m_wdata[c] = $urandom;
      m_sel[c]   = 4'($urandom);
   endtask

   // Spec rule: first requester searching upward from last+1, wrapping.
   function automatic int model_pick(input logic [NUM_CH-1:0] r, input int last);
      for (int k = 1; k <= NUM_CH; k++) begin
         if (r[(last + k) % NUM_CH]) return (last + k) % NUM_CH;
      end
      return -1;
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst         = 1'b0;
      bus_ack_i   = 1'b0;
      bus_rdata_i = '0;
      clear_masters();
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      logic [NUM_CH-1:0] chv;
      chv = NUM_CH'(1 << v.ch);
      @(negedge clk);
      m_req        = chv;
      m_we[v.ch]   = v.we;
      m_addr[v.ch] = v.addr;
      m_wdata[v.ch]= v.wdata;
      m_sel[v.ch]  = v.sel;
      apply();
      bus_ack_i = 1'b0;
      #1 check("vec_stall_c0", stall_o, chv);
      for (int c = 1; c <= v.ack_cyc; c++) begin
         @(negedge clk);
         if (c < v.ack_cyc) begin
            check("vec_bus_req", bus_req_o, 1);
            check("vec_bus_we", bus_we_o, v.we);
            check("vec_bus_addr", bus_addr_o, v.addr);
            check("vec_bus_wdata", bus_wdata_o, v.wdata);
            check("vec_bus_sel", bus_sel_o, v.sel);
            check("vec_no_ack", ch_ack_o, 0);
            check("vec_stall", stall_o, chv);
            bus_ack_i   = (c - 1 == v.wait_n);
            bus_rdata_i = bus_ack_i ? v.srd : 32'hBAD0_0000 + 32'(c);
            m_addr[v.ch]  = $urandom;
            m_wdata[v.ch] = $urandom;
            apply();
         end else begin
            check("vec_ack", ch_ack_o, chv);
            check("vec_err", ch_err_o, v.err ? chv : '0);
            check("vec_rdata", ch_rdata_o, v.exp_rd);
            check("vec_bus_req_drop", bus_req_o, 0);
            check("vec_stall_ack", stall_o, 0);
            bus_ack_i = 1'b0;
            m_req     = '0;
            apply();
         end
      end
      $display("[TB] vec %0d ch%0d we=%0b addr=0x%08h ack_cyc=%0d err=%0b rdata=0x%08h",
               idx, v.ch, v.we, v.addr, v.ack_cyc, ch_err_o != 0, ch_rdata_o);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [NUM_CH-1:0] reqv;
      logic [NUM_CH-1:0] ackv;
      logic [NUM_CH-1:0] exp_ack;
      logic              s_we;
      logic [AW-1:0]     s_addr;
      logic [DW-1:0]     s_wdata;
      logic [SW-1:0]     s_sel;
      logic [DW-1:0]     srd;
      logic              err_e;
      int                last_m, g, w, nb;

      vecs[0] = '{0, 1'b0, 32'h0000_0040, 32'h0,         4'hF, 0,       32'hDEAD_BEEF, 2,  1'b0, 32'hDEAD_BEEF};
      vecs[1] = '{1, 1'b1, 32'h0000_0100, 32'h1234_5678, 4'h3, 0,       32'hCAFE_F00D, 2,  1'b0, 32'h0};
      vecs[2] = '{2, 1'b0, 32'h0000_2000, 32'h0,         4'hF, 7,       32'h0123_4567, 9,  1'b0, 32'h0123_4567};
      vecs[3] = '{3, 1'b1, 32'h0000_3004, 32'hA5A5_0F0F, 4'hC, TIMEOUT, 32'hFFFF_FFFF, 10, 1'b0, 32'h0};
      vecs[4] = '{0, 1'b0, 32'h0000_0044, 32'h0,         4'hF, TIMEOUT, 32'hA5A5_A5A5, 10, 1'b0, 32'hA5A5_A5A5};
      vecs[5] = '{1, 1'b0, 32'h0000_0048, 32'h0,         4'hF, NEVER,   32'h5555_5555, 10, 1'b1, 32'h0};
      vecs[6] = '{2, 1'b0, 32'h0000_004C, 32'h0,         4'hF, 1,       32'h0000_0077, 3,  1'b0, 32'h0000_0077};

      rst = 1'b1;
      bus_ack_i = 1'b0;
      bus_rdata_i = '0;
      clear_masters();

      // Reset values, sampled while reset is held.
      @(negedge clk);
      rst = 1'b0;
      m_req = '1;
      apply();
      @(negedge clk);
      check("rst_ack", ch_ack_o, 0);
      check("rst_err", ch_err_o, 0);
      check("rst_rdata", ch_rdata_o, 0);
      check("rst_bus_req", bus_req_o, 0);
      check("rst_bus_we", bus_we_o, 0);
      check("rst_bus_addr", bus_addr_o, 0);
      check("rst_bus_wdata", bus_wdata_o, 0);
      check("rst_bus_sel", bus_sel_o, 0);
      clear_masters();
      @(negedge clk);
      rst = 1'b1;

      // Contention: ch0 and ch1 together, zero-wait slave.
      @(negedge clk);
      m_req = 4'b0011;
      m_addr[0] = 32'h10;
      m_addr[1] = 32'h20;
      apply();
      for (int c = 1; c <= 9; c++) begin
         @(negedge clk);
         exp_ack = (c == 2 || c == 8) ? 4'b0001 : (c == 5) ? 4'b0010 : 4'b0000;
         check("cont_ack", ch_ack_o, exp_ack);
         check("cont_stall", stall_o, m_req & ~exp_ack);
         if (exp_ack != 0) check("cont_rdata", ch_rdata_o, 32'h1000 + 32'(c - 1));
         if (c == 1 || c == 7) check("cont_addr", bus_addr_o, 32'h10);
         if (c == 4) check("cont_addr", bus_addr_o, 32'h20);
         if (exp_ack != 0)
            $display("[TB] contention ack=%b cycle=%0d rdata=0x%08h", ch_ack_o, c, ch_rdata_o);
         bus_ack_i   = bus_req_o;
         bus_rdata_i = 32'h1000 + 32'(c);
         if (c == 8) begin
            m_req = '0;
            apply();
         end
      end
      bus_ack_i = 1'b0;

      for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

      // Async reset while BUSY: last grant was ch2, so ch0..ch2 request -> ch0.
      @(negedge clk);
      for (int i = 0; i < NUM_CH; i++) begin
         m_we[i]   = 1'b0;
         m_addr[i] = 32'h5000 + 32'(i * 4);
      end
      m_req = 4'b0111;
      apply();
      @(negedge clk);
      check("arst_pre_req", bus_req_o, 1);
      check("arst_pre_addr", bus_addr_o, 32'h5000);
      m_req = 4'b1111;
      apply();
      #2 rst = 1'b0;
      #1;
      check("arst_bus_req", bus_req_o, 0);
      check("arst_bus_addr", bus_addr_o, 0);
      check("arst_ack", ch_ack_o, 0);
      @(negedge clk);
      rst = 1'b1;
      for (int k = 0; k <= 13; k++) begin
         @(negedge clk);
         exp_ack = (k % 3 == 1) ? NUM_CH'(1 << ((k / 3) % NUM_CH)) : '0;
         check("rot_ack", ch_ack_o, exp_ack);
         if (k == 0) check("rot_first_addr", bus_addr_o, 32'h5000);
         if (exp_ack != 0) $display("[TB] rotation ack=%b step=%0d", ch_ack_o, k);
         bus_ack_i = bus_req_o;
      end
      bus_ack_i = 1'b0;
      m_req = '0;
      apply();

      // Randomized traffic against the arbitration model.
      do_reset();
      last_m = NUM_CH - 1;
      for (int t = 0; t < 200; t++) begin
         @(negedge clk);
         check("rnd_idle_ack", ch_ack_o, 0);
         check("rnd_idle_busreq", bus_req_o, 0);
         check("rnd_idle_stall", stall_o, m_req);
         for (int c = 0; c < NUM_CH; c++)
            if (!m_req[c] && $urandom_range(0, 2) == 0) new_req(c);
         bus_ack_i   = 1'($urandom_range(0, 1));
         bus_rdata_i = $urandom;
         apply();
         reqv = m_req;
         if (reqv == 0) continue;

         g       = model_pick(reqv, last_m);
         last_m  = g;
         s_we    = m_we[g];
         s_addr  = m_addr[g];
         s_wdata = m_wdata[g];
         s_sel   = m_sel[g];
         w       = $urandom_range(0, TIMEOUT + 2);
         err_e   = (w > TIMEOUT);
         nb      = err_e ? TIMEOUT + 1 : w + 1;
         srd     = $urandom;
         for (int b = 0; b < nb; b++) begin
            @(negedge clk);
            check("rnd_bus_req", bus_req_o, 1);
            check("rnd_bus_we", bus_we_o, s_we);
            check("rnd_bus_addr", bus_addr_o, s_addr);
            check("rnd_bus_wdata", bus_wdata_o, s_wdata);
            check("rnd_bus_sel", bus_sel_o, s_sel);
            check("rnd_busy_ack", ch_ack_o, 0);
            check("rnd_busy_rdata", ch_rdata_o, 0);
            check("rnd_busy_stall", stall_o, m_req);
            bus_ack_i   = (b == w);
            bus_rdata_i = (b == w) ? srd : $urandom;
            if ($urandom_range(0, 3) == 0) begin
               m_addr[g]  = $urandom;
               m_wdata[g] = $urandom;
               m_sel[g]   = 4'($urandom);
               m_we[g]    = ~m_we[g];
            end
            if ($urandom_range(0, 7) == 0) m_req[g] = 1'b0;
            for (int c = 0; c < NUM_CH; c++)
               if (!m_req[c] && c != g && $urandom_range(0, 7) == 0) new_req(c);
            apply();
         end
         @(negedge clk);
         ackv = NUM_CH'(1 << g);
         check("rnd_ack", ch_ack_o, ackv);
         check("rnd_err", ch_err_o, err_e ? ackv : '0);
         check("rnd_rdata", ch_rdata_o, (!err_e && !s_we) ? srd : '0);
         check("rnd_bus_req_drop", bus_req_o, 0);
         check("rnd_resp_stall", stall_o, m_req & ~ackv);
         $display("[TB] rnd %0d req=%b grant=ch%0d we=%0b addr=0x%08h wait=%0d err=%0b rdata=0x%08h",
                  t, reqv, g, s_we, s_addr, w, err_e, ch_rdata_o);
         bus_ack_i   = 1'($urandom_range(0, 1));
         bus_rdata_i = $urandom;
         m_req[g]    = 1'b0;
         if ($urandom_range(0, 1) == 1) new_req(g);
         apply();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_bus_arb.md
Name: mem_bus_arb

Overview:
- Parametrised N-channel memory bus arbiter for the pipelined core.
- Replaces the separate fixed-latency rom/ram ports with one shared memory bus that tolerates variable slave latency.
- Channels (ch0 = instruction fetch, ch1 = data mem stage, extra channels for DMA/debug) compete with round-robin fairness.
- Per-channel stall outputs feed the pipeline stall controller; a timeout aborts hung slaves with an error pulse.

Parameters:
NUM_CH, 2, number of requesting channels (2..8)
AW, 32, address width
DW, 32, data width (multiple of 8)
TIMEOUT, 255, max BUSY cycles awaiting bus_ack_i before abort (>=1)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-low reset
ch_req_i  in  NUM_CH  per-channel request; held high until that channel's ack
ch_we_i  in  NUM_CH  1 = write, 0 = read
ch_addr_i  in  NUM_CH*AW  channel i at [i*AW +: AW]
ch_wdata_i  in  NUM_CH*DW  write data per channel
ch_sel_i  in  NUM_CH*DW/8  byte enables per channel
ch_ack_o  out  NUM_CH  one-cycle completion pulse, one-hot or zero
ch_err_o  out  NUM_CH  one-cycle timeout pulse, coincident with ack
ch_rdata_o  out  DW  read data, valid while ch_ack_o is nonzero
stall_o  out  NUM_CH  stall_o[i] = ch_req_i[i] & ~ch_ack_o[i]
bus_req_o  out  1  slave request, held until bus_ack_i
bus_we_o  out  1  write enable to slave
bus_addr_o  out  AW  address to slave
bus_wdata_o  out  DW  write data to slave
bus_sel_o  out  DW/8  byte enables to slave
bus_ack_i  in  1  slave completion, valid only while bus_req_o = 1
bus_rdata_i  in  DW  slave read data, sampled with bus_ack_i

Behaviour:
- Reset (rst = 0, async): state IDLE; all outputs 0; grant register 0; timeout counter 0; round-robin pointer last = NUM_CH-1, so ch0 wins first.
- FSM: IDLE -> BUSY -> RESP -> IDLE.
- IDLE:
  - If any ch_req_i bit is set, grant the first requester searching from last+1 modulo NUM_CH.
  - Latch that channel's we/addr/wdata/sel into the bus registers.
  - Set bus_req_o = 1 and last = grant. Next state BUSY.
  - No requests: stay IDLE.
- BUSY:
  - Bus outputs held stable; counter increments each cycle.
  - bus_ack_i = 1: capture bus_rdata_i (reads only; writes capture 0), drop bus_req_o, next state RESP.
  - Counter reaches TIMEOUT without ack: drop bus_req_o, rdata = 0, set error flag, next state RESP.
  - Ack and timeout in the same cycle: ack wins, no error.
- RESP (one cycle):
  - ch_ack_o[grant] = 1; ch_err_o[grant] = error flag; ch_rdata_o = captured data.
  - Clear counter and flag. Next state IDLE; a new arbitration happens in the following cycle.
- Latency:
  - Request seen in cycle 0 -> bus_req_o in cycle 1 -> earliest bus_ack_i in cycle 1 -> ch_ack_o in cycle 2.
  - Minimum turnaround is 3 cycles per transaction.
- Master drops ch_req_i mid-transaction: the transaction completes normally and the ack still pulses (master ignores it).
- Request inputs are ignored outside IDLE; changes to a granted channel's addr/data after grant have no effect.
- All requesters active continuously: grants rotate 0,1,..,NUM_CH-1,0; no starvation.
- Single channel requesting back-to-back: re-granted every 3 cycles regardless of pointer position.
- bus_ack_i while bus_req_o = 0: ignored.
- Reset mid-transaction: everything clears immediately; the pending ack is lost and the master re-requests.
- ch_rdata_o is 0 whenever no ack is asserted.

Decomposition:
- Shared package/defines: FSM state encodings (ARB_IDLE, ARB_BUSY, ARB_RESP), bus width defaults.
- Natural sub-module: rr_pick, a combinational round-robin priority encoder (inputs: req vector and last pointer; output: grant index plus valid).

Test Plan:
- Reset then single read: ch0 reads 0x0000_0040; slave acks in cycle 1 with 0xDEADBEEF -> ch_ack_o = 01 in cycle 2, ch_rdata_o = 0xDEADBEEF, stall_o[0] high in cycles 0-1.
- Contention: ch0 and ch1 request together, zero-wait slave -> grant order ch0, ch1, ch0; ack pulses in cycles 2, 5, 8.
- Wait states: slave acks 7 cycles after bus_req_o rises -> bus_addr_o/bus_wdata_o/bus_sel_o stable throughout; ch_ack_o 1 cycle after bus_ack_i.
- Timeout: TIMEOUT = 4, slave never acks -> ch_ack_o and ch_err_o pulse together in cycle 6; ch_rdata_o = 0; next request is served normally.
- Write with byte enables: ch1 writes 0x12345678, sel = 4'b0011, addr 0x100 -> bus outputs match; ch_rdata_o = 0 on ack.
- Async reset asserted in BUSY, between clock edges -> bus_req_o drops immediately; after release ch0 gets first grant (NUM_CH = 4, all requesting).
